// File: rtl/idct_coef_pkg.sv
// HEVC inverse-DCT coefficient tables shared by the MAC column and its stages.
// coef() returns the constant multiplier for a given mode, stage and output column.
package idct_coef_pkg;

   localparam int COEF_W = 8;

   typedef logic signed [COEF_W-1:0] coef_t;

   localparam coef_t T8 [8][8] = '{
      '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
      '{ 8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
      '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
      '{ 8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
      '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
      '{ 8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
      '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
      '{ 8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
   };

   localparam coef_t T4 [4][4] = '{
      '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
      '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83},
      '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
      '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36}
   };

   // In 4-point mode stages 4..7 and output columns 4..7 contribute nothing.
   function automatic coef_t coef(input logic mode4, input logic [2:0] k, input logic [2:0] idx);
      coef_t c;
      c = T8[k][idx];
      if (mode4) begin
         c = (k[2] || idx[2]) ? '0 : T4[k[1:0]][idx[1:0]];
      end
      return c;
   endfunction

endpackage

// File: rtl/idct_mac_stage.sv
// One constant-multiply-accumulate stage of the IDCT column, carrying the
// vector's valid, mode, rounding offset and shift alongside the partial sum.
module idct_mac_stage
   import idct_coef_pkg::*;
#(
   parameter int DW      = 16,
   parameter int AW      = 32,
   parameter int K       = 0,
   parameter int OUT_IDX = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] x_i,
   input  logic [AW-1:0]        acc_i,
   input  logic                 valid_i,
   input  logic                 mode_i,
   input  logic [AW-1:0]        add_i,
   input  logic [4:0]           shift_i,
   output logic [AW-1:0]        acc_o,
   output logic                 valid_o,
   output logic                 mode_o,
   output logic [AW-1:0]        add_o,
   output logic [4:0]           shift_o
);

   localparam coef_t C8 = coef(1'b0, 3'(K), 3'(OUT_IDX));
   localparam coef_t C4 = coef(1'b1, 3'(K), 3'(OUT_IDX));

   coef_t                cSel;
   logic signed [AW-1:0] xExt;
   logic signed [AW-1:0] cExt;
   logic signed [AW-1:0] prod;
   logic [AW-1:0]        acc_d;
   logic [AW-1:0]        acc_q;
   logic                 valid_q;
   logic                 mode_q;
   logic [AW-1:0]        add_q;
   logic [4:0]           shift_q;

   // The product wraps modulo 2^AW, matching the accumulator.
   always_comb begin
      cSel  = mode_i ? C4 : C8;
      xExt  = {{(AW-DW){x_i[DW-1]}}, x_i};
      cExt  = {{(AW-COEF_W){cSel[COEF_W-1]}}, cSel};
      prod  = xExt * cExt;
      acc_d = acc_i + prod;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         valid_q <= 1'b0;
         mode_q  <= 1'b0;
         add_q   <= '0;
         shift_q <= '0;
      end else begin
         acc_q   <= acc_d;
         valid_q <= valid_i;
         mode_q  <= mode_i;
         add_q   <= add_i;
         shift_q <= shift_i;
      end
   end

   assign acc_o   = acc_q;
   assign valid_o = valid_q;
   assign mode_o  = mode_q;
   assign add_o   = add_q;
   assign shift_o = shift_q;

endmodule

// File: rtl/idct_mac_column_p.sv
// Systolic IDCT MAC column: eight skewed MAC stages, a rounding-shift register
// and a saturating output register, plus a one-cycle forward copy of the inputs.
module idct_mac_column_p
   import idct_coef_pkg::*;
#(
   parameter int DW      = 16,
   parameter int AW      = 32,
   parameter int OW      = 16,
   parameter int OUT_IDX = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [8*DW-1:0]      d_in,
   input  logic                 in_valid,
   input  logic                 mode_4pt,
   input  logic [AW-1:0]        add,
   input  logic [4:0]           shift,
   output logic signed [OW-1:0] d_out,
   output logic                 out_valid,
   output logic                 sat_flag,
   output logic [8*DW-1:0]      d_prop,
   output logic                 prop_valid
);

   localparam logic signed [AW:0]   RND_MAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW:0]   RND_MIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};
   localparam logic signed [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic signed [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

   logic [AW-1:0] accW   [9];
   logic          validW [9];
   logic          modeW  [9];
   logic [AW-1:0] addW   [9];
   logic [4:0]    shiftW [9];

   assign accW[0]   = '0;
   assign validW[0] = in_valid;
   assign modeW[0]  = mode_4pt;
   assign addW[0]   = add;
   assign shiftW[0] = shift;

   for (genvar k = 0; k < 8; k++) begin : g_stage
      idct_mac_stage #(
         .DW      (DW),
         .AW      (AW),
         .K       (k),
         .OUT_IDX (OUT_IDX)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .x_i     (d_in[k*DW +: DW]),
         .acc_i   (accW[k]),
         .valid_i (validW[k]),
         .mode_i  (modeW[k]),
         .add_i   (addW[k]),
         .shift_i (shiftW[k]),
         .acc_o   (accW[k+1]),
         .valid_o (validW[k+1]),
         .mode_o  (modeW[k+1]),
         .add_o   (addW[k+1]),
         .shift_o (shiftW[k+1])
      );
   end

   logic signed [AW:0]   sum;
   logic signed [AW:0]   rnd_d;
   logic signed [AW:0]   rnd_q;
   logic                 rndValid_q;
   logic signed [OW-1:0] dOut_d;
   logic signed [OW-1:0] dOut_q;
   logic                 sat_d;
   logic                 sat_q;
   logic                 outValid_q;
   logic [8*DW-1:0]      dProp_q;
   logic                 propValid_q;

   // One guard bit keeps the unsigned offset from flipping the sign; an arithmetic
   // shift of AW or more on this width already yields pure sign fill.
   always_comb begin
      sum   = $signed({accW[8][AW-1], accW[8]}) + $signed({1'b0, addW[8]});
      rnd_d = sum >>> shiftW[8];
   end

   always_comb begin
      dOut_d = dOut_q;
      sat_d  = sat_q;
      if (rndValid_q) begin
         if (rnd_q > RND_MAX) begin
            dOut_d = OUT_MAX;
            sat_d  = 1'b1;
         end else if (rnd_q < RND_MIN) begin
            dOut_d = OUT_MIN;
            sat_d  = 1'b1;
         end else begin
            dOut_d = rnd_q[OW-1:0];
            sat_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rnd_q       <= '0;
         rndValid_q  <= 1'b0;
         dOut_q      <= '0;
         sat_q       <= 1'b0;
         outValid_q  <= 1'b0;
         dProp_q     <= '0;
         propValid_q <= 1'b0;
      end else begin
         rnd_q       <= rnd_d;
         rndValid_q  <= validW[8];
         dOut_q      <= dOut_d;
         sat_q       <= sat_d;
         outValid_q  <= rndValid_q;
         dProp_q     <= d_in;
         propValid_q <= in_valid;
      end
   end

   assign d_out      = dOut_q;
   assign sat_flag   = sat_q;
   assign out_valid  = outValid_q;
   assign d_prop     = dProp_q;
   assign prop_valid = propValid_q;

endmodule

// File: doc/idct_mac_column_p.md
Name: idct_mac_column_p

Overview:
- Parametrised systolic multiply-accumulate column for the inverse-DCT array.
- Computes one output sample, d_out = sat((sum_k T[k][OUT_IDX]*x[k] + add) >>> shift), using HEVC integer coefficients.
- Supports run-time selection of 8-point or 4-point mode, valid tracking, per-vector rounding controls and output saturation.
- Instances are chained side by side: each forwards its inputs one cycle later to the next column (OUT_IDX+1).

Parameters:
- DW, 16, signed input sample width.
- AW, 32, signed accumulator width; all products and partial sums are sign-extended to AW.
- OW, 16, signed output width; saturation target.
- OUT_IDX, 0, output index 0..7; selects coefficient column T[*][OUT_IDX].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- d_in  in  8*DW  packed samples; x[k] = d_in[k*DW +: DW].
- in_valid  in  1  qualifies x[0] of a vector; x[k] of the same vector is presented k cycles later.
- mode_4pt  in  1  sampled with in_valid; 1 = 4-point transform.
- add  in  AW  unsigned rounding offset, sampled with in_valid.
- shift  in  5  arithmetic right shift, sampled with in_valid.
- d_out  out  OW  result.
- out_valid  out  1  one-cycle strobe per vector.
- sat_flag  out  1  valid with out_valid; 1 = result was clipped.
- d_prop  out  8*DW  d_in delayed one cycle (all lanes).
- prop_valid  out  1  in_valid delayed one cycle.

Behaviour:
- Reset (async assert, sync release): all pipeline registers, d_out, out_valid, sat_flag, d_prop and prop_valid go to 0.
- Stage 0: acc0 <= sext(x[0])*c0. The vector's valid, mode, add and shift are captured alongside.
- Stage k (1..7): acc_k <= acc_{k-1} + sext(x[k])*c_k.
  - x[k] is sampled in the cycle when stage k-1 holds the vector.
  - Valid, mode, add and shift advance one stage per cycle with the data.
- 8-point mode: c_k = T8[k][OUT_IDX].
- 4-point mode:
  - Stages 0..3 use T4[k][OUT_IDX].
  - Stages 4..7 add 0, so latency stays constant.
  - If OUT_IDX >= 4, all coefficients are 0: d_out = sat(add >>> shift), still delivered with out_valid.
- Round/clip stage: r = (acc7 + zext(add)) >>> shift, computed in AW+1 bits.
  - r > 2^(OW-1)-1 gives d_out = max, sat_flag = 1.
  - r < -2^(OW-1) gives d_out = min, sat_flag = 1.
  - Otherwise d_out = r[OW-1:0], sat_flag = 0.
  - shift >= AW behaves as a full arithmetic shift (result 0 or -1).
- Latency: out_valid asserts exactly 9 cycles after the in_valid sample edge. Throughput is one vector per cycle, with no stalls.
- When out_valid = 0, d_out and sat_flag hold their last values.
- Bubbles (in_valid = 0): the stage valid is cleared; accumulator contents are don't-care and never surface.
- Mode changes between back-to-back vectors are legal. Each vector uses the mode sampled with its own in_valid.
- d_prop and prop_valid are always registered copies of the inputs, regardless of mode.
- Reset mid-operation: all in-flight vectors are discarded. No out_valid appears until a new vector has run 9 cycles after reset release.
- Accumulator overflow wraps modulo 2^AW. The sum is not checked for overflow before rounding; sizing AW correctly is the integrator's job.

Decomposition:
- Package idct_coef_pkg holds:
  - T8[8][8] HEVC matrix; row 1 is 89,75,50,18,-18,-50,-75,-89.
  - T4[4][4], with rows 64,64,64,64 / 83,36,-36,-83 / 64,-64,-64,64 / 36,-83,83,-36.
  - The coefficient width constant (8 bits signed).
  - A function coef(mode, k, idx).
- Sub-module idct_mac_stage: one constant-multiply-add stage with its side-band pipeline (valid, mode, add, shift). The column instantiates 8 of them via generate, followed by the round/clip logic.

Test Plan:
- 8-pt, OUT_IDX=0, x=all 1, add=64, shift=7: out_valid at +9 cycles; sum 479, (479+64)>>>7 gives d_out=4, sat_flag=0.
- 8-pt, OUT_IDX=0, x0=-128, rest 0, add=64, shift=7: -8192 gives (-8128)>>>7, so d_out=-64.
- 8-pt, OUT_IDX=0, x1=32767, rest 0, add=0, shift=0: 2916263 gives d_out=32767, sat_flag=1. With x1=-32768 instead: d_out=-32768, sat_flag=1.
- 4-pt, OUT_IDX=1, x0..x3=1, add=0, shift=0: 64+36-64-83 gives d_out=-47. The same vector with OUT_IDX=5 and add=5 gives d_out=5.
- Back-to-back vectors on consecutive cycles alternating mode and shift: each result appears on consecutive cycles with its own parameters. A single-cycle in_valid gap produces exactly one out_valid gap. d_prop and prop_valid equal the inputs delayed one cycle.
- Assert reset with 5 vectors in flight: all outputs are 0 immediately and no stale out_valid follows. A new vector after release produces its correct result 9 cycles later.
